// File: rtl/xor_rr_arbiter.sv
// rtl/xor_rr_arbiter.sv - round-robin shared registered XOR unit for NREQ requesters
// Optional macro XOR_PARITY_EN adds the registered rsp_parity output.
module xor_rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [NREQ-1:0]         req_ready,
    output logic                    rsp_valid,
    output logic [WIDTH-1:0]        rsp_data,
    output logic [IDW-1:0]          rsp_id,
    input  logic                    rsp_ready,
`ifdef XOR_PARITY_EN
    output logic                    rsp_parity,
`endif
    output logic                    busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t             state;
    logic [IDW-1:0]     rr_ptr;

    logic [NREQ-1:0]    grant;
    logic [IDW-1:0]     win_id;
    logic [WIDTH-1:0]   win_a;
    logic [WIDTH-1:0]   win_b;
    logic               found;

    // Search starts at rr_ptr and wraps, so the last served requester is checked last.
    always_comb begin
        int idx;
        grant  = '0;
        win_id = '0;
        win_a  = '0;
        win_b  = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                win_id     = IDW'(idx);
                win_a      = req_a[idx*WIDTH +: WIDTH];
                win_b      = req_b[idx*WIDTH +: WIDTH];
            end
        end
    end

    assign req_ready = (state == IDLE && !rst) ? grant : '0;
    assign busy      = (state == RESP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_id     <= '0;
`ifdef XOR_PARITY_EN
            rsp_parity <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        rsp_data   <= win_a ^ win_b;
                        rsp_id     <= win_id;
                        rsp_valid  <= 1'b1;
`ifdef XOR_PARITY_EN
                        rsp_parity <= ^(win_a ^ win_b);
`endif
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rr_ptr    <= (rsp_id == IDW'(NREQ - 1)) ? '0 : rsp_id + IDW'(1);
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xor_rr_arbiter.sv
// tb/tb_xor_rr_arbiter.sv - randomized and directed checks of xor_rr_arbiter against a reference model
module tb_xor_rr_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic [WIDTH-1:0]  rsp_data;
    logic [1:0]        rsp_id;
    logic              rsp_ready;
    logic              busy;
`ifdef XOR_PARITY_EN
    logic              rsp_parity;
`endif

    xor_rr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready),
`ifdef XOR_PARITY_EN
        .rsp_parity(rsp_parity),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    bit       m_resp;
    int       m_ptr;
    bit       m_valid;
    int       m_data;
    int       m_id;

    // values observed in the most recent cycle
    logic [NREQ-1:0]  obs_ready;
    logic             obs_valid;
    logic [WIDTH-1:0] obs_data;
    logic [1:0]       obs_id;
    logic             obs_busy;
    int               grants[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic int op(input logic [NREQ*WIDTH-1:0] bus, input int i);
        return int'((bus >> (i * WIDTH)) & 32'hFF);
    endfunction

    task automatic cycle();
        int w;
        logic [NREQ-1:0] exp_ready;
        @(negedge clk);
        w = pick(req_valid, m_ptr);
        exp_ready = (rst || m_resp || w < 0) ? '0 : NREQ'(1 << w);
        obs_ready = req_ready;
        obs_valid = rsp_valid;
        obs_data  = rsp_data;
        obs_id    = rsp_id;
        obs_busy  = busy;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        check("rsp_data",  32'(rsp_data),  32'(m_data));
        check("rsp_id",    32'(rsp_id),    32'(m_id));
        check("busy",      32'(busy),      32'(m_resp));
`ifdef XOR_PARITY_EN
        check("rsp_parity", 32'(rsp_parity), 32'(^(m_data[7:0])));
`endif
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) grants.push_back(i);
        @(posedge clk);
        if (rst) begin
            m_resp = 0; m_ptr = 0; m_valid = 0; m_data = 0; m_id = 0;
        end else if (!m_resp) begin
            if (w >= 0) begin
                m_data  = op(req_a, w) ^ op(req_b, w);
                m_id    = w;
                m_valid = 1;
                m_resp  = 1;
            end
        end else if (rsp_ready) begin
            m_valid = 0;
            m_resp  = 0;
            m_ptr   = (m_id + 1) % NREQ;
        end
        #1;
    endtask

    initial begin
        int exp_order[5] = '{0, 1, 2, 3, 0};
        rst = 1; req_valid = 4'hF; req_a = '0; req_b = '0; rsp_ready = 0;
        m_resp = 0; m_ptr = 0; m_valid = 0; m_data = 0; m_id = 0;
        @(posedge clk); #1;

        // reset with all requesting
        repeat (2) cycle();
        check("reset_ready", 32'(obs_ready), 32'h0);
        check("reset_busy", 32'(obs_busy), 32'h0);

        // single request from id 2
        rst = 0; req_valid = 4'b0100; rsp_ready = 1;
        req_a = 32'h00A5_0000; req_b = 32'h000F_0000;
        cycle();
        check("single_grant", 32'(obs_ready), 32'h4);
        req_valid = 4'b0000; req_a = 32'hFFFF_FFFF;
        cycle();
        check("single_data", 32'(obs_data), 32'hAA);
        check("single_id", 32'(obs_id), 32'h2);
        cycle();

        // fresh reset so round-robin starts from 0
        rst = 1; cycle(); rst = 0;
        grants.delete();
        req_valid = 4'hF; rsp_ready = 1;
        for (int i = 0; i < 10; i++) begin
            req_a = $urandom; req_b = $urandom;
            cycle();
        end
        check("rr_count", 32'(grants.size()), 32'd5);
        for (int i = 0; i < 5 && i < grants.size(); i++)
            check($sformatf("rr_order%0d", i), 32'(grants[i]), 32'(exp_order[i]));

        // backpressure: grant then hold off for 5 cycles
        rsp_ready = 0; req_valid = 4'b0010;
        cycle();
        for (int i = 0; i < 5; i++) begin
            req_a = $urandom; req_b = $urandom;
            cycle();
            check("bp_busy", 32'(obs_busy), 32'h1);
        end
        rsp_ready = 1; req_valid = 4'b0;
        cycle();
        cycle();
        check("bp_idle", 32'(obs_busy), 32'h0);

        // wrap/priority: serve 3 then 0 must beat 3
        req_valid = 4'b1000; cycle(); req_valid = 4'b0; cycle();
        req_valid = 4'b1001;
        cycle();
        check("wrap_grant", 32'(obs_ready), 32'h1);
        req_valid = 4'b0; cycle(); cycle();

        // mid-op reset while waiting in RESP
        rsp_ready = 0; req_valid = 4'b0100; cycle(); req_valid = 4'b0; cycle();
        rst = 1; cycle(); rst = 0;
        cycle();
        check("midrst_valid", 32'(obs_valid), 32'h0);
        req_valid = 4'b0010; rsp_ready = 1;
        cycle();
        check("midrst_grant", 32'(obs_ready), 32'h2);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 39) == 0);
            req_valid = NREQ'($urandom);
            req_a     = $urandom;
            req_b     = $urandom;
            rsp_ready = ($urandom_range(0, 2) != 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
